echo_request_input: RTL and testbench
=====================================

// Module: echo_request_input
// PURPOSE
//   Request-side demarshaller feeding the Echo core's echoReq port.
//   Accepts 32-bit portal write words tagged with a method number and decodes single say and burst-say messages.
//   Buffers payload words in a FIFO and issues them downstream with a RDY/ENA handshake.
//   Sits between the portal request bus and l_class_OC_Echo; it is the mirror of the indication-output stage.
// PARAMETERS
//   DEPTH      8   payload FIFO entries; power of 2, >=2
//   BURST_MAX  15  largest legal burst count (1..255)
// PORTS
//   CLK                       in   1   clock
//   RST_N                     in   1   reset, synchronous, active-low
//   wr_method                 in   16  method number of current write word
//   wr_data                   in   32  write word
//   EN_wr                     in   1   write strobe; word taken when EN_wr && RDY_wr
//   RDY_wr                    out  1   ready to take a write word
//   messageSize_size_methodNumber in 16 method number to query
//   messageSize_size          out  16  bits per write word for that method
//   RDY_messageSize_size      out  1   constant 1
//   say_v                     out  32  payload word to Echo (FIFO head)
//   say__RDY                  in   1   Echo echoReq__RDY
//   say__ENA                  out  1   Echo echoReq__ENA
//   err_count                 out  16  count of rejected words/messages
//   msg_count                 out  32  say handshakes completed (ECHO_REQ_STATS_EN only)
// BEHAVIOUR
//   Reset (RST_N low at a CLK edge): state=IDLE, FIFO empty, burst_left=0, err_count=0, msg_count=0.
//     Outputs after reset: RDY_wr=1, say__ENA=0, say_v=0.
//   RDY_wr = !fifo_full in every state; header/error words also wait on this, for simplicity.
//   Method 0 (say), state IDLE: wr_data pushed to FIFO.
//   Method 1 (burst) in IDLE: wr_data[7:0]=C is the header word.
//     C in 1..BURST_MAX: burst_left=C, state->BURST; nothing pushed.
//     C==0 or C>BURST_MAX: err_count+1; stay IDLE.
//   State BURST: each accepted word, whatever its method, is pushed and burst_left-1; on reaching 0, state->IDLE.
//   Any other method in IDLE: word dropped, err_count+1.
//   err_count saturates at 16'hFFFF.
//   Output handshake:
//     say__ENA = !fifo_empty && say__RDY; say_v = FIFO head, or 0 when empty.
//     Pop happens on the cycle say__ENA is high.
//     Latency: a word accepted in cycle N is first visible on say_v in cycle N+1; no bypass.
//   Simultaneous push+pop: legal whenever RDY_wr is high; occupancy unchanged.
//     Full: RDY_wr=0 even if a pop occurs that cycle; no combinational ready path.
//   Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
//     full = MSBs differ && low bits equal; empty = pointers equal.
//   messageSize_size: combinational; 32 for method 0 or 1, else 0.
//   Reset mid-burst: burst aborted, FIFO contents discarded, no error counted.
// CONFIGURATION
//   ECHO_REQ_STATS_EN defined: msg_count port present.
//     msg_count+1 per say__ENA cycle; wraps modulo 2^32; reset 0.
//   Undefined: msg_count port and counter absent; all other behaviour identical.
// TESTING
//   1. Reset, write method0 data=32'hCAFE0001, say__RDY=1 -> next cycle say__ENA=1, say_v=32'hCAFE0001; FIFO empty after.
//   2. say__RDY=0, write DEPTH method-0 words -> RDY_wr drops after the 8th.
//      Then say__RDY=1 -> 8 words out in order, one per cycle; RDY_wr=1 one cycle after the first pop.
//   3. Method1 C=3, then words 1,2,3 -> three say handshakes with values 1,2,3; state back to IDLE.
//      A 4th method-7 word -> err_count=1.
//   4. Method1 C=0, then method1 C=16 -> err_count=2; no say__ENA; IDLE.
//   5. Method1 C=5, two payload words, RST_N low one cycle -> FIFO empty, say__ENA=0, err_count=0.
//      Then method0 word -> delivered normally.
//   6. ECHO_REQ_STATS_EN on: 10 says -> msg_count=10; query method 2 -> messageSize_size=0; method 0 -> 32.

Source files
------------

// File: rtl/echo_request_input.sv
// Request-side demarshaller for the Echo core: decodes say / burst-say portal writes,
// buffers payload in a FIFO and hands it to echoReq. Optional msg_count under ECHO_REQ_STATS_EN.
module echo_request_input #(
  parameter int DEPTH     = 8,
  parameter int BURST_MAX = 15
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] wr_method,
  input  logic [31:0] wr_data,
  input  logic        EN_wr,
  output logic        RDY_wr,
  input  logic [15:0] messageSize_size_methodNumber,
  output logic [15:0] messageSize_size,
  output logic        RDY_messageSize_size,
  output logic [31:0] say_v,
  input  logic        say__RDY,
  output logic        say__ENA,
  output logic [15:0] err_count
`ifdef ECHO_REQ_STATS_EN
  ,
  output logic [31:0] msg_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] BURST_MAX_B = 8'(BURST_MAX);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [7:0]  burst_left, burst_left_next;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [31:0] mem [DEPTH];
  logic        fifo_full, fifo_empty;
  logic        accept, push, pop, err_inc;
  logic [7:0]  hdr_count;

  // Extra pointer MSB distinguishes full from empty when the low bits coincide.
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_empty = (wr_ptr == rd_ptr);

  assign RDY_wr    = !fifo_full;
  assign accept    = EN_wr && RDY_wr;
  assign hdr_count = wr_data[7:0];

  assign say__ENA = !fifo_empty && say__RDY;
  assign pop      = say__ENA;
  assign say_v    = fifo_empty ? 32'd0 : mem[rd_ptr[AW-1:0]];

  assign messageSize_size     = ((messageSize_size_methodNumber == 16'd0) ||
                                 (messageSize_size_methodNumber == 16'd1)) ? 16'd32 : 16'd0;
  assign RDY_messageSize_size = 1'b1;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= IDLE;
      burst_left <= 8'd0;
    end else begin
      state      <= state_next;
      burst_left <= burst_left_next;
    end
  end

  // In a burst every accepted word is payload regardless of its method tag.
  always_comb begin
    state_next      = state;
    burst_left_next = burst_left;
    push            = 1'b0;
    err_inc         = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (wr_method == 16'd0) begin
            push = 1'b1;
          end else if (wr_method == 16'd1) begin
            if ((hdr_count != 8'd0) && (hdr_count <= BURST_MAX_B)) begin
              burst_left_next = hdr_count;
              state_next      = BURST;
            end else begin
              err_inc = 1'b1;
            end
          end else begin
            err_inc = 1'b1;
          end
        end
        BURST: begin
          push            = 1'b1;
          burst_left_next = burst_left - 8'd1;
          if (burst_left == 8'd1) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      err_count <= 16'd0;
    end else if (err_inc && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end

`ifdef ECHO_REQ_STATS_EN
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      msg_count <= 32'd0;
    end else if (say__ENA) begin
      msg_count <= msg_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_echo_request_input.sv
// Scoreboard bench for echo_request_input: stimulus queues expected say_v words,
// a forked monitor pops and compares them on every say__ENA.
module tb_echo_request_input;

  logic        CLK;
  logic        RST_N;
  logic [15:0] wr_method;
  logic [31:0] wr_data;
  logic        EN_wr;
  logic        RDY_wr;
  logic [15:0] messageSize_size_methodNumber;
  logic [15:0] messageSize_size;
  logic        RDY_messageSize_size;
  logic [31:0] say_v;
  logic        say__RDY;
  logic        say__ENA;
  logic [15:0] err_count;
`ifdef ECHO_REQ_STATS_EN
  logic [31:0] msg_count;
`endif

  int vec_count;
  int miscompares;
  logic [31:0] exp_q[$];

  echo_request_input #(.DEPTH(8), .BURST_MAX(15)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .wr_method(wr_method),
    .wr_data(wr_data),
    .EN_wr(EN_wr),
    .RDY_wr(RDY_wr),
    .messageSize_size_methodNumber(messageSize_size_methodNumber),
    .messageSize_size(messageSize_size),
    .RDY_messageSize_size(RDY_messageSize_size),
    .say_v(say_v),
    .say__RDY(say__RDY),
    .say__ENA(say__ENA),
    .err_count(err_count)
`ifdef ECHO_REQ_STATS_EN
    ,
    .msg_count(msg_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Word is presented once RDY_wr is high; expect_push marks it as payload bound for say_v.
  task automatic applyStimulus(input logic [15:0] method, input logic [31:0] data, input bit expect_push);
    int waited;
    waited = 0;
    while (RDY_wr !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    if (RDY_wr !== 1'b1) begin
      vec_count++;
      miscompares++;
      $display("[TB] FAIL rdy_wr_timeout: got RDY_wr=%b, expected 1 within 100 cycles", RDY_wr);
    end
    wr_method = method;
    wr_data   = data;
    EN_wr     = 1'b1;
    if (expect_push) exp_q.push_back(data);
    tick();
    EN_wr = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      tick();
      waited++;
    end
    if (exp_q.size() != 0) begin
      vec_count++;
      miscompares++;
      $display("[TB] FAIL drain_timeout: got %0d words pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  task automatic pulseReset();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
  endtask

  task automatic monitor();
    logic [31:0] expv;
    forever begin
      @(negedge CLK);
      if (say__ENA === 1'b1) begin
        vec_count++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_say: got say_v=%h, expected no handshake", say_v);
        end else begin
          expv = exp_q.pop_front();
          if (say_v !== expv) begin
            miscompares++;
            $display("[TB] FAIL say_v: got %h, expected %h", say_v, expv);
          end
        end
      end
    end
  endtask

  initial begin
    vec_count   = 0;
    miscompares = 0;
    RST_N       = 1'b0;
    EN_wr       = 1'b0;
    wr_method   = 16'd0;
    wr_data     = 32'd0;
    say__RDY    = 1'b1;
    messageSize_size_methodNumber = 16'd0;
    fork
      monitor();
    join_none
    tick();
    tick();
    RST_N = 1'b1;

    // Reset state and single say
    checkOutput("reset_rdy_wr", {31'd0, RDY_wr}, 32'd1);
    checkOutput("reset_say_ena", {31'd0, say__ENA}, 32'd0);
    checkOutput("reset_say_v", say_v, 32'd0);
    checkOutput("reset_err_count", {16'd0, err_count}, 32'd0);
    applyStimulus(16'd0, 32'hCAFE0001, 1'b1);
    checkOutput("t1_say_ena", {31'd0, say__ENA}, 32'd1);
    checkOutput("t1_say_v", say_v, 32'hCAFE0001);
    tick();
    checkOutput("t1_empty_ena", {31'd0, say__ENA}, 32'd0);
    checkOutput("t1_empty_say_v", say_v, 32'd0);

    // Fill FIFO with consumer stalled, then release
    say__RDY = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(16'd0, 32'h100 + 32'(i), 1'b1);
    checkOutput("t2_full_rdy_wr", {31'd0, RDY_wr}, 32'd0);
    say__RDY = 1'b1;
    #1;
    checkOutput("t2_full_pop_rdy_wr", {31'd0, RDY_wr}, 32'd0);
    tick();
    checkOutput("t2_after_pop_rdy_wr", {31'd0, RDY_wr}, 32'd1);
    drain();

    // Burst of 3 with mixed method tags, then a stray method 7
    applyStimulus(16'd1, 32'd3, 1'b0);
    applyStimulus(16'd0, 32'd1, 1'b1);
    applyStimulus(16'd5, 32'd2, 1'b1);
    applyStimulus(16'd1, 32'd3, 1'b1);
    applyStimulus(16'd7, 32'd4, 1'b0);
    checkOutput("t3_err_count", {16'd0, err_count}, 32'd1);
    drain();

    // Illegal burst counts (0 and BURST_MAX+1), and a minimal burst of 1
    pulseReset();
    applyStimulus(16'd1, 32'd0, 1'b0);
    applyStimulus(16'd1, 32'd16, 1'b0);
    checkOutput("t4_err_count", {16'd0, err_count}, 32'd2);
    checkOutput("t4_say_ena", {31'd0, say__ENA}, 32'd0);
    applyStimulus(16'd9, 32'hDEAD0000, 1'b0);
    checkOutput("t4_idle_err_count", {16'd0, err_count}, 32'd3);
    applyStimulus(16'd1, 32'h0000_FF01, 1'b0);
    applyStimulus(16'd3, 32'hB0B0B0B0, 1'b1);
    applyStimulus(16'd1, 32'd0, 1'b0);
    checkOutput("t4_burst1_done_err", {16'd0, err_count}, 32'd4);
    drain();

    // Reset in the middle of a burst
    say__RDY = 1'b0;
    applyStimulus(16'd1, 32'd5, 1'b0);
    applyStimulus(16'd0, 32'h51, 1'b0);
    applyStimulus(16'd0, 32'h52, 1'b0);
    pulseReset();
    say__RDY = 1'b1;
    #1;
    checkOutput("t5_say_ena", {31'd0, say__ENA}, 32'd0);
    checkOutput("t5_say_v", say_v, 32'd0);
    checkOutput("t5_err_count", {16'd0, err_count}, 32'd0);
    checkOutput("t5_rdy_wr", {31'd0, RDY_wr}, 32'd1);
    applyStimulus(16'd0, 32'hD00D0005, 1'b1);
    drain();
    applyStimulus(16'd2, 32'd0, 1'b0);
    checkOutput("t5_idle_err_count", {16'd0, err_count}, 32'd1);

    // Message size query
    messageSize_size_methodNumber = 16'd2;
    #1;
    checkOutput("t6_msgsize_m2", {16'd0, messageSize_size}, 32'd0);
    messageSize_size_methodNumber = 16'd0;
    #1;
    checkOutput("t6_msgsize_m0", {16'd0, messageSize_size}, 32'd32);
    messageSize_size_methodNumber = 16'd1;
    #1;
    checkOutput("t6_msgsize_m1", {16'd0, messageSize_size}, 32'd32);
    checkOutput("t6_msgsize_rdy", {31'd0, RDY_messageSize_size}, 32'd1);

`ifdef ECHO_REQ_STATS_EN
    pulseReset();
    checkOutput("t6_msg_count_reset", msg_count, 32'd0);
    for (int i = 0; i < 10; i++) applyStimulus(16'd0, 32'hA000 + 32'(i), 1'b1);
    drain();
    checkOutput("t6_msg_count", msg_count, 32'd10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
